// File: rtl/usb_bit_encoder_if.sv
// Serial-bit handshake and USB line-level signals between the upstream shifter and the encoder.
// master = upstream bit source, slave = encoder.
interface usb_bit_encoder_if;
    logic in_bit;
    logic in_valid;
    logic in_last;
    logic stall;
    logic dp;
    logic dm;
    logic busy;
    logic done;

    modport master (
        output in_bit, in_valid, in_last,
        input  stall, dp, dm, busy, done
    );

    modport slave (
        input  in_bit, in_valid, in_last,
        output stall, dp, dm, busy, done
    );
endinterface

// File: rtl/usb_bit_encoder.sv
// USB NRZI line encoder with optional bit stuffing and SE0,SE0,J end-of-packet.
// Define USB_BITSTUFF_EN to insert a stuffed 0 after every six consecutive 1s.
module usb_bit_encoder (
    input  logic              clk,
    input  logic              rst_b,
    usb_bit_encoder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_STUFF,
        S_EOP1,
        S_EOP2,
        S_EOPJ
    } state_e;

    state_e r_state;
    state_e w_next_state;
    logic   r_dp;
    logic   r_dm;
    logic   r_done;
    logic   w_next_dp;
    logic   w_next_dm;
    logic   w_next_done;
    logic   w_stall;
    logic   w_accept;
    logic   w_stuff_due;

`ifdef USB_BITSTUFF_EN
    logic [2:0] r_ones;
    logic [2:0] w_next_ones;
    logic       r_last;
    logic       w_next_last;

    // The 1 being accepted now is the sixth in a row.
    assign w_stuff_due = bus.in_bit && (r_ones == 3'd5);
`else
    assign w_stuff_due = 1'b0;
`endif

    assign w_stall   = (r_state == S_STUFF) || (r_state == S_EOP1) ||
                       (r_state == S_EOP2)  || (r_state == S_EOPJ);
    assign w_accept  = bus.in_valid && !w_stall;

    assign bus.stall = w_stall;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.dp    = r_dp;
    assign bus.dm    = r_dm;
    assign bus.done  = r_done;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        w_next_state = r_state;
        w_next_dp    = r_dp;
        w_next_dm    = r_dm;
        w_next_done  = 1'b0;
`ifdef USB_BITSTUFF_EN
        w_next_ones  = r_ones;
        w_next_last  = r_last;
`endif
        unique case (r_state)
            S_IDLE, S_SEND: begin
                if (w_accept) begin
                    // NRZI: a 0 toggles J<->K, a 1 holds the line.
                    if (!bus.in_bit) begin
                        w_next_dp = ~r_dp;
                        w_next_dm = ~r_dm;
                    end
`ifdef USB_BITSTUFF_EN
                    w_next_ones = bus.in_bit ? (r_ones + 3'd1) : 3'd0;
                    w_next_last = bus.in_last;
`endif
                    if (w_stuff_due) begin
                        w_next_state = S_STUFF;
                    end else if (bus.in_last) begin
                        w_next_state = S_EOP1;
                    end else begin
                        w_next_state = S_SEND;
                    end
                end
            end
`ifdef USB_BITSTUFF_EN
            S_STUFF: begin
                w_next_dp    = ~r_dp;
                w_next_dm    = ~r_dm;
                w_next_ones  = 3'd0;
                w_next_last  = 1'b0;
                w_next_state = r_last ? S_EOP1 : S_SEND;
            end
`endif
            S_EOP1: begin
                w_next_dp    = 1'b0;
                w_next_dm    = 1'b0;
                w_next_state = S_EOP2;
            end
            S_EOP2: begin
                w_next_dp    = 1'b0;
                w_next_dm    = 1'b0;
                w_next_state = S_EOPJ;
            end
            S_EOPJ: begin
                // Leaving EOP on J also sets the NRZI reference for the next packet.
                w_next_dp    = 1'b1;
                w_next_dm    = 1'b0;
                w_next_done  = 1'b1;
`ifdef USB_BITSTUFF_EN
                w_next_ones  = 3'd0;
                w_next_last  = 1'b0;
`endif
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_dp    <= 1'b1;
            r_dm    <= 1'b0;
            r_done  <= 1'b0;
`ifdef USB_BITSTUFF_EN
            r_ones  <= 3'd0;
            r_last  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its peers.
            r_state <= w_next_state;
            r_dp    <= w_next_dp;
            r_dm    <= w_next_dm;
            r_done  <= w_next_done;
`ifdef USB_BITSTUFF_EN
            r_ones  <= w_next_ones;
            r_last  <= w_next_last;
`endif
        end
    end

endmodule

// File: doc/usb_bit_encoder.md
USB_BIT_ENCODER -- requirements
Module: usb_bit_encoder

Interface
REQ-001 clk  input  1  system clock; all state changes on posedge.
REQ-002 rst_b  input  1  asynchronous, active-low reset.
REQ-003 in_bit  input  1  serial data bit from the upstream PISO shift register (LSB-first stream).
REQ-004 in_valid  input  1  in_bit valid this cycle.
REQ-005 in_last  input  1  qualifies in_bit as the final data bit of the packet.
REQ-006 stall  output  1  encoder cannot accept a bit this cycle; upstream drives its shift enable with ~stall.
REQ-007 dp  output  1  D+ line level, registered.
REQ-008 dm  output  1  D- line level, registered.
REQ-009 busy  output  1  packet in progress (any state other than IDLE).
REQ-010 done  output  1  one-cycle pulse when EOP completes.

Function
REQ-011 A bit SHALL be accepted on a posedge when in_valid=1 and stall=0; there is no other accept path.
REQ-012 States SHALL be IDLE, SEND, STUFF, EOP1, EOP2, EOPJ.
REQ-013 stall SHALL be combinational from state: 1 in STUFF, EOP1, EOP2 and EOPJ; 0 in IDLE and SEND.
REQ-014 NRZI: an accepted 0 SHALL toggle the line between J (dp=1, dm=0) and K (dp=0, dm=1); an accepted 1 SHALL hold it; dp/dm update on the edge that accepts the bit (1-cycle latency).
REQ-015 IDLE -> SEND on accept of a bit without in_last; IDLE -> EOP1 on accept with in_last, unless REQ-018 applies.
REQ-016 In SEND, in_valid=0 SHALL hold the line, the ones counter and the state (gap tolerated, no error).
REQ-017 A 3-bit ones counter SHALL increment on each accepted 1, clear on each accepted 0 and on each stuffed bit, and clear in IDLE.
REQ-018 When an accepted 1 brings the counter to 6, next state SHALL be STUFF regardless of in_last; in_last is remembered in a flag.
REQ-019 STUFF (one cycle) SHALL toggle the line (stuffed 0) and clear the counter; next state is EOP1 if the flag is set, else SEND.
REQ-020 Accept with in_last in SEND (no stuff pending) -> EOP1.
REQ-021 EOP1 and EOP2 SHALL drive SE0 (dp=0, dm=0); EOPJ SHALL drive J; EOPJ -> IDLE with done=1 for exactly that transition cycle (done registered, high the cycle the state is IDLE again).
REQ-022 After EOP the NRZI reference level SHALL be J for the next packet.
REQ-023 in_valid while stall=1 SHALL be ignored; upstream holds the bit.

Reset
REQ-024 rst_b low SHALL force state IDLE, dp=1, dm=0, busy=0, done=0, ones counter 0, last flag 0, immediately and asynchronously, including mid-packet or mid-EOP.
REQ-025 First posedge after rst_b rises SHALL behave as IDLE with line at J.

Configuration
REQ-026 Macro USB_BITSTUFF_EN SHALL control bit stuffing.
REQ-027 Defined: REQ-017 to REQ-019 apply.
REQ-028 Undefined: no ones counter, STUFF state unreachable, stall never asserts in SEND; any run length of 1s passes unmodified.

Verification
REQ-029 Reset, then bits 0,0,0,0,0,0,0,1 (SYNC, last on final bit), in_valid continuous -> line K,J,K,J,K,J,K,K on successive cycles, then SE0,SE0,J, done pulse, stall never high before EOP1.
REQ-030 USB_BITSTUFF_EN defined, seven consecutive 1s after one 0 -> stall high exactly one cycle after 6th 1, line toggles in that cycle, 7th 1 accepted next cycle with line held.
REQ-031 Six 1s with in_last on the 6th -> STUFF cycle (toggle) then EOP1, EOP2, EOPJ; done pulses once.
REQ-032 in_valid dropped 3 cycles mid-packet after five 1s, then two more 1s -> line held during gap, stuff occurs after the 6th 1 (counter survives gap).
REQ-033 rst_b asserted during EOP2 -> dp=1, dm=0, busy=0 immediately; no done pulse; next packet starts from J.
REQ-034 USB_BITSTUFF_EN undefined, eight 1s -> stall stays 0, line constant for eight cycles.
